// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // ceil(log2(n)), never less than 1 so a WIDTH=1 counter still has a bit.
  function automatic int clog2_min1(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell: combinational sum and carry of a + b + cin.
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through full_adder, LSB first.
// Result appears WIDTH+1 cycles after start with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2_min1(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_b_q, sum_sh_q, sum_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [CW-1:0]    count_q;
  logic             fa_sum, fa_cout;
  logic             last_bit;
  logic             load;

  full_adder u_fa (
    .sum  (fa_sum),
    .cout (fa_cout),
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .cin  (carry_q)
  );

  assign last_bit = (count_q == CW'(WIDTH - 1));
  // Shift-and-or form keeps the expression legal when WIDTH is 1.
  assign sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        // The edge leaving DONE may already accept the next operation.
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      if (load) begin
        sh_a_q   <= a;
        sh_b_q   <= b;
        carry_q  <= cin;
        count_q  <= '0;
        sum_sh_q <= '0;
      end else if (state_q == RUN) begin
        sh_a_q   <= sh_a_q >> 1;
        sh_b_q   <= sh_b_q >> 1;
        carry_q  <= fa_cout;
        count_q  <= count_q + CW'(1);
        sum_sh_q <= sum_sh_d;
      end
      // Published result only moves on the DONE entry edge.
      if (state_q == RUN && last_bit) begin
        sum_q  <= sum_sh_d;
        cout_q <= fa_cout;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 and WIDTH=1 instances on one clock.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       st8, ci8, busy8, done8, co8;
  logic [7:0] a8, b8, sum8;
  logic       st1, ci1, busy1, done1, co1;
  logic [0:0] a1, b1, sum1;

  int total;
  int bad;
  int stable_err;
  int cyc;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (st8),
    .a     (a8),
    .b     (b8),
    .cin   (ci8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (st1),
    .a     (a1),
    .b     (b1),
    .cin   (ci1),
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an 8-bit operation from the #1-after-edge phase and returns the
  // number of edges up to and including the one that raises done.
  // poke_at > 0 pulses start with a=FF on that cycle while busy.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                     input int poke_at, output int n);
    logic [7:0] prev_s;
    logic       prev_c;
    prev_s = sum8;
    prev_c = co8;
    a8  = ta;
    b8  = tb_v;
    ci8 = tc;
    st8 = 1'b1;
    n   = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      st8 = (n == poke_at);
      if (n == poke_at) a8 = 8'hFF;
      if (done8) break;
      if (sum8 !== prev_s || co8 !== prev_c) stable_err++;
    end
  endtask

  task automatic op1(input logic ta, input logic tb_v, input logic tc, output int n);
    a1  = ta;
    b1  = tb_v;
    ci1 = tc;
    st1 = 1'b1;
    n   = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      st1 = 1'b0;
      if (done1) break;
    end
  endtask

  initial begin
    logic [1:0] fa_tab [8];
    logic [2:0] idx;
    total = 0;
    bad = 0;
    stable_err = 0;
    rst = 1'b1;
    st8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    st1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  ci1 = 1'b0;
    fa_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_done", {31'b0, done8}, 32'd0);
    chk("rst_sum",  {24'b0, sum8},  32'h00);
    chk("rst_cout", {31'b0, co8},   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Zero operands and start-to-done latency.
    op8(8'h00, 8'h00, 1'b0, 0, cyc);
    chk("zero_lat",  cyc, 32'd9);
    chk("zero_sum",  {24'b0, sum8}, 32'h00);
    chk("zero_cout", {31'b0, co8},  32'd0);
    chk("zero_busy", {31'b0, busy8}, 32'd1);
    @(posedge clk); #1;
    chk("zero_done_pulse", {31'b0, done8}, 32'd0);

    op8(8'hFF, 8'h01, 1'b0, 0, cyc);
    chk("ff01_lat",  cyc, 32'd9);
    chk("ff01_sum",  {24'b0, sum8}, 32'h00);
    chk("ff01_cout", {31'b0, co8},  32'd1);
    @(posedge clk); #1;

    op8(8'hA5, 8'h5A, 1'b1, 0, cyc);
    chk("a55a_sum",  {24'b0, sum8}, 32'h00);
    chk("a55a_cout", {31'b0, co8},  32'd1);
    @(posedge clk); #1;

    // Ignored start while running; previous result (00/1) must hold in RUN.
    stable_err = 0;
    op8(8'h3C, 8'h0F, 1'b0, 3, cyc);
    chk("ign_lat",    cyc, 32'd9);
    chk("ign_sum",    {24'b0, sum8}, 32'h4B);
    chk("ign_cout",   {31'b0, co8},  32'd0);
    chk("ign_stable", stable_err, 32'd0);
    @(posedge clk); #1;
    chk("ign_single_done", {31'b0, done8}, 32'd0);
    chk("ign_not_queued",  {31'b0, busy8}, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("ign_no_late_done", {31'b0, done8}, 32'd0);
    chk("ign_sum_kept",     {24'b0, sum8},  32'h4B);

    // Reset in the fourth RUN cycle clears outputs, no result emitted.
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", {31'b0, busy8}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", {31'b0, busy8}, 32'd0);
    chk("mrst_done", {31'b0, done8}, 32'd0);
    chk("mrst_sum",  {24'b0, sum8},  32'h00);
    chk("mrst_cout", {31'b0, co8},   32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    op8(8'h80, 8'h80, 1'b0, 0, cyc);
    chk("post_rst_lat",  cyc, 32'd9);
    chk("post_rst_sum",  {24'b0, sum8}, 32'h00);
    chk("post_rst_cout", {31'b0, co8},  32'd1);
    @(posedge clk); #1;

    op8(8'hC8, 8'h64, 1'b1, 0, cyc);
    chk("c864_sum",  {24'b0, sum8}, 32'h2D);
    chk("c864_cout", {31'b0, co8},  32'd1);
    @(posedge clk); #1;

    // Back-to-back: next start presented during the done cycle.
    op8(8'h12, 8'h34, 1'b0, 0, cyc);
    chk("b2b1_sum",  {24'b0, sum8}, 32'h46);
    chk("b2b1_cout", {31'b0, co8},  32'd0);
    stable_err = 0;
    op8(8'h7F, 8'h01, 1'b1, 0, cyc);
    chk("b2b_spacing", cyc, 32'd9);
    chk("b2b2_sum",    {24'b0, sum8}, 32'h81);
    chk("b2b2_cout",   {31'b0, co8},  32'd0);
    chk("b2b_stable",  stable_err, 32'd0);
    @(posedge clk); #1;

    // WIDTH=1 instance against the full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      op1(idx[2], idx[1], idx[0], cyc);
      chk($sformatf("w1_lat_%0d", i), cyc, 32'd2);
      chk($sformatf("w1_res_%0d", i), {30'b0, co1, sum1}, {30'b0, fa_tab[i]});
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
